// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer controller: lights an N_LEDS thermometer bar, hands off to the
// random-delay block, then times the player's button press in milliseconds.
module reaction_timer_ctrl #(
  parameter int N_LEDS    = 10,
  parameter int CNT_W     = 14,
  parameter int MAX_COUNT = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              ms_tick,
  input  logic              trigger,
  input  logic              time_out,
  input  logic              reaction,
  output logic              en_lfsr,
  output logic              start_delay,
  output logic [N_LEDS-1:0] ledr,
  output logic [CNT_W-1:0]  reaction_ms,
  output logic [CNT_W-1:0]  best_ms,
  output logic              result_valid,
  output logic              false_start
);

  localparam int STEP_W = $clog2(N_LEDS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_LEDS - 1);
  localparam logic [STEP_W-1:0] FULL_STEP = STEP_W'(N_LEDS);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LIGHT = 3'd1,
    S_DELAY = 3'd2,
    S_REACT = 3'd3,
    S_DONE  = 3'd4,
    S_FOUL  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    ms_q, ms_d;
  logic [CNT_W-1:0]    best_q, best_d;
  logic                blink_q, blink_d;
  logic                reaction_q;
  logic                rise;
  logic [N_LEDS-1:0]   therm;
  logic [N_LEDS-1:0]   ledr_q, ledr_d;
  logic                start_delay_q, start_delay_d;
  logic                en_lfsr_q, en_lfsr_d;
  logic                result_valid_q, result_valid_d;
  logic                false_start_q, false_start_d;

  assign rise = reaction & ~reaction_q;

  // Bar fills from the MSB: bit gi is lit once step exceeds N_LEDS-1-gi.
  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_therm
    assign therm[gi] = (step_d > STEP_W'(N_LEDS - 1 - gi));
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    ms_d          = ms_q;
    best_d        = best_q;
    blink_d       = blink_q;
    start_delay_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FOUL: begin
        if (trigger) begin
          state_d = S_LIGHT;
          step_d  = '0;
          ms_d    = '0;
          blink_d = 1'b0;
        end else if (state_q == S_FOUL && tick) begin
          blink_d = ~blink_q;
        end
      end
      S_LIGHT: begin
        if (rise) begin
          state_d = S_FOUL;
          blink_d = 1'b0;
        end else if (tick) begin
          if (step_q == LAST_STEP) begin
            state_d       = S_DELAY;
            step_d        = FULL_STEP;
            start_delay_d = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (rise) begin
          state_d = S_FOUL;
          blink_d = 1'b0;
        end else if (time_out) begin
          state_d = S_REACT;
          ms_d    = '0;
        end
      end
      S_REACT: begin
        // A press wins over a coincident ms_tick so the capture is the pre-increment count.
        if (rise) begin
          state_d = S_DONE;
          if (ms_q < best_q) best_d = ms_q;
        end else if (ms_tick && ms_q < MAX_CNT) begin
          ms_d = ms_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    en_lfsr_d      = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FOUL);
    result_valid_d = (state_d == S_DONE);
    false_start_d  = (state_d == S_FOUL);

    case (state_d)
      S_LIGHT: ledr_d = therm;
      S_DELAY: ledr_d = '1;
      S_FOUL:  ledr_d = blink_d ? '1 : '0;
      default: ledr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      step_q         <= '0;
      ms_q           <= '0;
      best_q         <= MAX_CNT;
      blink_q        <= 1'b0;
      reaction_q     <= 1'b0;
      ledr_q         <= '0;
      start_delay_q  <= 1'b0;
      en_lfsr_q      <= 1'b1;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      ms_q           <= ms_d;
      best_q         <= best_d;
      blink_q        <= blink_d;
      reaction_q     <= reaction;
      ledr_q         <= ledr_d;
      start_delay_q  <= start_delay_d;
      en_lfsr_q      <= en_lfsr_d;
      result_valid_q <= result_valid_d;
      false_start_q  <= false_start_d;
    end
  end

  assign en_lfsr      = en_lfsr_q;
  assign start_delay  = start_delay_q;
  assign ledr         = ledr_q;
  assign reaction_ms  = ms_q;
  assign best_ms      = best_q;
  assign result_valid = result_valid_q;
  assign false_start  = false_start_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: a 10-LED/9999 instance and a 4-LED/20 instance
// share stimulus; directed scenarios plus a random run against a reference model.
module tb_reaction_timer_ctrl;

  logic clk = 1'b0;
  logic reset, tick, ms_tick, trigger, time_out, reaction;

  logic        en0, sd0, rv0, fs0;
  logic [9:0]  ledr0;
  logic [13:0] rms0, best0;
  logic        en1, sd1, rv1, fs1;
  logic [3:0]  ledr1;
  logic [13:0] rms1, best1;

  int total = 0;
  int bad   = 0;

  localparam int M_IDLE = 0, M_LIGHT = 1, M_DELAY = 2, M_REACT = 3, M_DONE = 4, M_FOUL = 5;
  int P_N[2]   = '{10, 4};
  int P_MAX[2] = '{9999, 20};
  int m_st[2], m_step[2], m_prev[2], m_ms[2], m_best[2], m_blink[2], m_sd[2];

  reaction_timer_ctrl #(.N_LEDS(10), .CNT_W(14), .MAX_COUNT(9999)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .ms_tick(ms_tick), .trigger(trigger),
    .time_out(time_out), .reaction(reaction), .en_lfsr(en0), .start_delay(sd0),
    .ledr(ledr0), .reaction_ms(rms0), .best_ms(best0), .result_valid(rv0),
    .false_start(fs0));

  reaction_timer_ctrl #(.N_LEDS(4), .CNT_W(14), .MAX_COUNT(20)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .ms_tick(ms_tick), .trigger(trigger),
    .time_out(time_out), .reaction(reaction), .en_lfsr(en1), .start_delay(sd1),
    .ledr(ledr1), .reaction_ms(rms1), .best_ms(best1), .result_valid(rv1),
    .false_start(fs1));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_step[i] = 0; m_prev[i] = 0; m_ms[i] = 0;
      m_best[i] = P_MAX[i]; m_blink[i] = 0; m_sd[i] = 0;
    end
  endtask

  // Applies the game rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit pressed;
      pressed   = reaction && (m_prev[i] == 0);
      m_prev[i] = reaction ? 1 : 0;
      m_sd[i]   = 0;
      if (m_st[i] == M_IDLE || m_st[i] == M_DONE || m_st[i] == M_FOUL) begin
        if (trigger) begin
          m_st[i] = M_LIGHT; m_step[i] = 0; m_ms[i] = 0;
        end else if (m_st[i] == M_FOUL && tick) begin
          m_blink[i] = 1 - m_blink[i];
        end
      end else if (m_st[i] == M_LIGHT) begin
        if (pressed) begin
          m_st[i] = M_FOUL; m_blink[i] = 0;
        end else if (tick) begin
          m_step[i]++;
          if (m_step[i] == P_N[i]) begin
            m_st[i] = M_DELAY; m_sd[i] = 1;
          end
        end
      end else if (m_st[i] == M_DELAY) begin
        if (pressed) begin
          m_st[i] = M_FOUL; m_blink[i] = 0;
        end else if (time_out) begin
          m_st[i] = M_REACT; m_ms[i] = 0;
        end
      end else begin
        if (pressed) begin
          m_st[i] = M_DONE;
          if (m_ms[i] < m_best[i]) m_best[i] = m_ms[i];
        end else if (ms_tick && m_ms[i] < P_MAX[i]) begin
          m_ms[i]++;
        end
      end
    end
  endtask

  function automatic int exp_ledr(int i);
    int full;
    full = (1 << P_N[i]) - 1;
    case (m_st[i])
      M_LIGHT: return ((1 << m_step[i]) - 1) << (P_N[i] - m_step[i]);
      M_DELAY: return full;
      M_FOUL:  return (m_blink[i] != 0) ? full : 0;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic do_ms(input int n);
    ms_tick = 1'b1;
    repeat (n) step();
    ms_tick = 1'b0;
  endtask

  task automatic go_react();
    trigger = 1'b1; step(); trigger = 1'b0;
    do_ticks(10);
    time_out = 1'b1; step(); time_out = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if ({en0, sd0, rv0, fs0, ledr0} !== {4'b1000, 10'h000}) begin
      bad++; $display("FAIL reset_flags: got %b want %b", {en0, sd0, rv0, fs0, ledr0}, {4'b1000, 10'h000});
    end
    total++;
    if (rms0 !== 14'd0 || best0 !== 14'd9999) begin
      bad++; $display("FAIL reset_counts: got %0d/%0d want 0/9999", rms0, best0);
    end
  endtask

  task automatic test_light_sequence();
    logic [9:0] want;
    trigger = 1'b1; step(); trigger = 1'b0;
    total++;
    if (ledr0 !== 10'h000 || en0 !== 1'b0) begin
      bad++; $display("FAIL light_entry: got ledr=%h en=%b want 000/0", ledr0, en0);
    end
    for (int k = 1; k <= 10; k++) begin
      tick = 1'b1; step();
      want = 10'(((1 << k) - 1) << (10 - k));
      total++;
      if (ledr0 !== want) begin
        bad++; $display("FAIL light_bar k=%0d: got %h want %h", k, ledr0, want);
      end
      if (k == 4) begin
        total++;
        if (ledr1 !== 4'hF || sd1 !== 1'b1) begin
          bad++; $display("FAIL small_bar_delay: got ledr=%h sd=%b want F/1", ledr1, sd1);
        end
      end
      if (k == 10) begin
        total++;
        if (sd0 !== 1'b1) begin
          bad++; $display("FAIL start_delay_high: got %b want 1", sd0);
        end
      end
      tick = 1'b0; step();
      if (k == 10) begin
        total++;
        if (sd0 !== 1'b0 || ledr0 !== 10'h3FF) begin
          bad++; $display("FAIL start_delay_low: got sd=%b ledr=%h want 0/3ff", sd0, ledr0);
        end
      end
    end
  endtask

  task automatic test_react();
    time_out = 1'b1; step(); time_out = 1'b0;
    total++;
    if (ledr0 !== 10'h000 || rms0 !== 14'd0) begin
      bad++; $display("FAIL react_entry: got ledr=%h ms=%0d want 000/0", ledr0, rms0);
    end
    do_ms(237);
    reaction = 1'b1; step();
    total++;
    if (rms0 !== 14'd237 || best0 !== 14'd237 || rv0 !== 1'b1) begin
      bad++; $display("FAIL done_237: got ms=%0d best=%0d rv=%b want 237/237/1", rms0, best0, rv0);
    end
    total++;
    if (rms1 !== 14'd20 || best1 !== 14'd20 || rv1 !== 1'b1) begin
      bad++; $display("FAIL saturated: got ms=%0d best=%0d rv=%b want 20/20/1", rms1, best1, rv1);
    end
    reaction = 1'b0; step();
  endtask

  task automatic test_best_time();
    int rounds[2] = '{412, 150};
    int bests[2]  = '{237, 150};
    for (int r = 0; r < 2; r++) begin
      go_react();
      do_ms(rounds[r]);
      reaction = 1'b1; step();
      total++;
      if (rms0 !== 14'(rounds[r]) || best0 !== 14'(bests[r])) begin
        bad++; $display("FAIL best_round%0d: got ms=%0d best=%0d want %0d/%0d", r, rms0, best0, rounds[r], bests[r]);
      end
      reaction = 1'b0; step();
    end
  endtask

  task automatic test_false_start();
    trigger = 1'b1; step(); trigger = 1'b0;
    do_ticks(4);
    reaction = 1'b1; step();
    total++;
    if (fs0 !== 1'b1 || ledr0 !== 10'h000 || best0 !== 14'd150 || en0 !== 1'b1) begin
      bad++; $display("FAIL foul_entry: got fs=%b ledr=%h best=%0d en=%b want 1/000/150/1", fs0, ledr0, best0, en0);
    end
    reaction = 1'b0; step();
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      total++;
      if (ledr0 !== ((k % 2 == 1) ? 10'h3FF : 10'h000)) begin
        bad++; $display("FAIL foul_blink k=%0d: got %h want %h", k, ledr0, (k % 2 == 1) ? 10'h3FF : 10'h000);
      end
      step();
    end
    trigger = 1'b1; step(); trigger = 1'b0;
    total++;
    if (fs0 !== 1'b0 || en0 !== 1'b0) begin
      bad++; $display("FAIL foul_retrigger: got fs=%b en=%b want 0/0", fs0, en0);
    end
  endtask

  task automatic test_held_button();
    reaction = 1'b1; step();
    go_react();
    do_ms(20);
    total++;
    if (fs0 !== 1'b0 || rv0 !== 1'b0 || rms0 !== 14'd20) begin
      bad++; $display("FAIL held_no_press: got fs=%b rv=%b ms=%0d want 0/0/20", fs0, rv0, rms0);
    end
    reaction = 1'b0; step();
    reaction = 1'b1; step();
    total++;
    if (rv0 !== 1'b1 || rms0 !== 14'd20 || best0 !== 14'd20) begin
      bad++; $display("FAIL held_then_press: got rv=%b ms=%0d best=%0d want 1/20/20", rv0, rms0, best0);
    end
    reaction = 1'b0; step();
    trigger = 1'b1; step(); trigger = 1'b0;
    do_ticks(10);
    reaction = 1'b1; time_out = 1'b1; step();
    reaction = 1'b0; time_out = 1'b0;
    total++;
    if (fs0 !== 1'b1 || rv0 !== 1'b0) begin
      bad++; $display("FAIL press_with_timeout: got fs=%b rv=%b want 1/0", fs0, rv0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    go_react();
    do_ms(5);
    ms_tick = 1'b1; reaction = 1'b1; step();
    ms_tick = 1'b0; reaction = 1'b0;
    total++;
    if (rms0 !== 14'd5 || best0 !== 14'd5 || rms1 !== 14'd5 || best1 !== 14'd5) begin
      bad++; $display("FAIL tick_with_press: got %0d/%0d %0d/%0d want 5/5 5/5", rms0, best0, rms1, best1);
    end
    step();
  endtask

  task automatic test_async_reset();
    go_react();
    do_ms(99);
    total++;
    if (rms0 !== 14'd99) begin
      bad++; $display("FAIL pre_reset_count: got %0d want 99", rms0);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({en0, sd0, rv0, fs0, ledr0} !== {4'b1000, 10'h000} || rms0 !== 14'd0 || best0 !== 14'd9999) begin
      bad++; $display("FAIL async_reset: got flags=%b ledr=%h ms=%0d best=%0d want 1000/000/0/9999",
                      {en0, sd0, rv0, fs0}, ledr0, rms0, best0);
    end
    model_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic test_random();
    int a_ledr, a_ms, a_best, a_flags, e_flags;
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      trigger  = ($urandom_range(0, 29) == 0);
      tick     = ($urandom_range(0, 2) == 0);
      ms_tick  = ($urandom_range(0, 1) == 0);
      time_out = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) reaction = ~reaction;
      step();
      for (int i = 0; i < 2; i++) begin
        a_ledr  = (i == 0) ? int'(ledr0) : int'(ledr1);
        a_ms    = (i == 0) ? int'(rms0) : int'(rms1);
        a_best  = (i == 0) ? int'(best0) : int'(best1);
        a_flags = (i == 0) ? int'({en0, sd0, rv0, fs0}) : int'({en1, sd1, rv1, fs1});
        e_flags = ((m_st[i] == M_IDLE || m_st[i] == M_DONE || m_st[i] == M_FOUL) ? 8 : 0)
                + (m_sd[i] * 4) + ((m_st[i] == M_DONE) ? 2 : 0) + ((m_st[i] == M_FOUL) ? 1 : 0);
        total++;
        if (a_ledr !== exp_ledr(i) || a_ms !== m_ms[i] || a_best !== m_best[i] || a_flags !== e_flags) begin
          bad++;
          $display("FAIL random c=%0d dut%0d: got ledr=%h ms=%0d best=%0d flags=%b want %h/%0d/%0d/%b",
                   c, i, a_ledr, a_ms, a_best, a_flags[3:0], exp_ledr(i), m_ms[i], m_best[i], e_flags[3:0]);
        end
      end
    end
    reset = 1'b0; trigger = 1'b0; tick = 1'b0; ms_tick = 1'b0; time_out = 1'b0; reaction = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ms_tick = 1'b0; trigger = 1'b0; time_out = 1'b0; reaction = 1'b0;
    model_reset();
    test_reset();
    test_light_sequence();
    test_react();
    test_best_time();
    test_false_start();
    test_held_button();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Parametrised reaction-timer controller, successor to the fixed 10-LED countdown FSM. Lights a thermometer bar of N_LEDS LEDs one per tick, hands off to the external random-delay block, then times the player in milliseconds with an internal saturating counter. Adds false-start detection, an edge-detected reaction button, and a best-time register. Sits between the tick/ms prescalers, the LFSR and random-delay blocks, and the 7-segment display path.

Parameters:
N_LEDS, 10, number of LEDs in the bar (>= 2)
CNT_W, 14, width of the reaction and best-time counters
MAX_COUNT, 9999, saturation value of the ms counter (must fit in CNT_W bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle pulse per LED step (about 0.5 s)
ms_tick  input  1  one-cycle pulse every 1 ms
trigger  input  1  start-round request, sampled as a level
time_out  input  1  one-cycle pulse from the random-delay block
reaction  input  1  player button (level; rising edge detected internally)
en_lfsr  output  1  enables the LFSR; high only in IDLE, DONE and FOUL
start_delay  output  1  registered one-cycle pulse that starts the random delay
ledr  output  N_LEDS  LED bar
reaction_ms  output  CNT_W  live or captured reaction time in ms
best_ms  output  CNT_W  best valid time since reset
result_valid  output  1  high in DONE
false_start  output  1  high in FOUL

Behaviour:
- Reset (async): state IDLE, step=0, reaction_q=0, ledr=0, reaction_ms=0, best_ms=MAX_COUNT, start_delay=0, result_valid=0, false_start=0, blink=0.
- rise = reaction & ~reaction_q. reaction_q is registered every cycle, so a button held across rounds never counts as a press.
- States: IDLE, LIGHT, DELAY, REACT, DONE, FOUL.
- IDLE/DONE/FOUL:
  - en_lfsr=1.
  - trigger=1 -> LIGHT on the next edge, with step=0, ledr=0, reaction_ms=0, result_valid=0, false_start=0.
- LIGHT:
  - ledr has the top `step` bits set (MSB first): step=k gives k ones starting at bit N_LEDS-1.
  - tick increments step.
  - tick with step==N_LEDS-1 -> DELAY, step=N_LEDS (all LEDs on), start_delay=1 for exactly that one following cycle.
  - rise -> FOUL. rise has priority over a simultaneous tick.
- DELAY:
  - ledr all ones.
  - time_out -> REACT with ledr=0 and reaction_ms=0.
  - rise -> FOUL. rise has priority over a simultaneous time_out.
  - time_out in any other state is ignored.
- REACT:
  - Each ms_tick increments reaction_ms, holding at MAX_COUNT (no wrap).
  - rise -> DONE. An ms_tick in the same cycle is not applied, so the captured value is the pre-increment count.
- DONE:
  - reaction_ms frozen, result_valid=1, ledr=0.
  - On entry, best_ms <= reaction_ms if reaction_ms < best_ms (strict). A saturated MAX_COUNT result therefore never improves best_ms.
- FOUL:
  - false_start=1; reaction_ms and best_ms unchanged.
  - blink toggles on each tick; ledr = all ones when blink=1, else 0. blink is cleared on entry.
- start_delay is only ever a single-cycle pulse per round.
- Reset asserted mid-round returns to IDLE immediately and also clears best_ms to MAX_COUNT.
- Unused state encodings -> IDLE on the next edge.

Test Plan:
- Reset, trigger=1 for 1 cycle, 10 ticks -> ledr steps 0x000, 0x200, 0x300 … 0x3FF; start_delay is high for exactly 1 cycle after the 10th tick; en_lfsr=0.
- Continue: time_out pulse, 237 ms_ticks, reaction rise -> DONE, reaction_ms=237, result_valid=1, best_ms=237. Second round at 412 ms -> best_ms stays 237; third round at 150 ms -> best_ms=150.
- reaction rise after 4 ticks in LIGHT -> FOUL, false_start=1, ledr alternates 0x3FF/0x000 on each tick, best_ms unchanged; trigger -> LIGHT with false_start=0.
- reaction held high from a previous round through LIGHT/DELAY/REACT -> no FOUL or DONE until it is released and pressed again. reaction rise in the same cycle as time_out -> FOUL.
- With MAX_COUNT=20, 30 ms_ticks in REACT -> reaction_ms holds at 20; press -> DONE, best_ms not updated. ms_tick coincident with press at count 5 -> captured value 5.
- Assert reset in REACT at count 99 -> all outputs return to reset values asynchronously, best_ms=MAX_COUNT. With N_LEDS=4 -> DELAY after 4 ticks, ledr=4'hF.
